// File: rtl/sv_ex_if.sv
// sv_ex_if: execute handshake plus host limb port between the sequencer/host and sv_ex.
interface sv_ex_if #(
    parameter int unsigned LIMB_W = 32,
    parameter int unsigned NL     = 16
);
    localparam int unsigned LIMB_AW = (NL > 1) ? $clog2(NL) : 1;

    logic [14:0]         ex_i_i;
    logic                ex_v_i;
    logic                ex_r_o;
    logic                ex_c_o;
    logic                busy_o;
    logic                err_o;
    logic                host_we;
    logic [2:0]          host_reg;
    logic [LIMB_AW-1:0]  host_limb;
    logic [LIMB_W-1:0]   host_wdata;
    logic [LIMB_W-1:0]   host_rdata;

    modport master (
        output ex_i_i, ex_v_i, host_we, host_reg, host_limb, host_wdata,
        input  ex_r_o, ex_c_o, busy_o, err_o, host_rdata
    );

    modport slave (
        input  ex_i_i, ex_v_i, host_we, host_reg, host_limb, host_wdata,
        output ex_r_o, ex_c_o, busy_o, err_o, host_rdata
    );
endinterface

// File: rtl/sv_ex.sv
// sv_ex: limb-serial big-integer execution unit, one LIMB_W limb per cycle over BLOCK_SIZE registers.
// Optional feature macro: SV_EX_SHIFT_EN enables SHL1/SHR1 (and the MSB-first limb walk).
module sv_ex #(
    parameter int unsigned BLOCK_SIZE = 512,
    parameter int unsigned LIMB_W     = 32,
    parameter int unsigned NUM_REGS   = 8
) (
    input  logic   clk,
    input  logic   areset,
    sv_ex_if.slave ex
);
    localparam int unsigned NL      = BLOCK_SIZE / LIMB_W;
    localparam int unsigned LIMB_AW = (NL > 1) ? $clog2(NL) : 1;
    localparam logic [LIMB_AW-1:0] LAST = LIMB_AW'(NL - 1);

    localparam logic [3:0] OP_MOV   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_XOR   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_CMPEQ = 4'h6;
    localparam logic [3:0] OP_CMPLT = 4'h7;
`ifdef SV_EX_SHIFT_EN
    localparam logic [3:0] OP_SHL1  = 4'h8;
    localparam logic [3:0] OP_SHR1  = 4'h9;
`endif
    localparam logic [3:0] OP_CLR   = 4'hA;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ILL, S_DONE} state_t;

    state_t              state;
    logic [3:0]          op;
    logic [2:0]          rd, rs1, rs2;
    logic [LIMB_AW-1:0]  idx;
    logic                cy;
    logic                eq;

    logic [LIMB_W-1:0]   rf [NUM_REGS][NL];

    logic [LIMB_W-1:0]   a, b, res;
    logic [LIMB_W:0]     sum, dif;
    logic                cy_nxt, eq_nxt, wr, last, legal;
    logic [LIMB_AW-1:0]  idx_nxt;
    logic                unused_bits;

    assign unused_bits = ^ex.ex_i_i[14:13];

    // Opcode legality for the word presented in IDLE
    always_comb begin
        legal = (ex.ex_i_i[3:0] <= OP_CMPLT) || (ex.ex_i_i[3:0] == OP_CLR);
`ifdef SV_EX_SHIFT_EN
        if (ex.ex_i_i[3:0] == OP_SHL1 || ex.ex_i_i[3:0] == OP_SHR1)
            legal = 1'b1;
`endif
    end

    // Limb walk: SHR1 counts down from the top limb, everything else counts up
    always_comb begin
        idx_nxt = idx + LIMB_AW'(1);
        last    = (idx == LAST);
`ifdef SV_EX_SHIFT_EN
        if (op == OP_SHR1) begin
            idx_nxt = idx - LIMB_AW'(1);
            last    = (idx == '0);
        end
`endif
    end

    // One-limb datapath; cy doubles as carry, borrow and shift-in bit
    always_comb begin
        a      = rf[rs1][idx];
        b      = rf[rs2][idx];
        sum    = {1'b0, a} + {1'b0, b} + (LIMB_W+1)'(cy);
        dif    = {1'b0, a} - {1'b0, b} - (LIMB_W+1)'(cy);
        res    = '0;
        cy_nxt = 1'b0;
        wr     = 1'b1;
        eq_nxt = eq & (a == b);
        case (op)
            OP_MOV:   res = a;
            OP_ADD:   begin res = sum[LIMB_W-1:0]; cy_nxt = sum[LIMB_W]; end
            OP_SUB:   begin res = dif[LIMB_W-1:0]; cy_nxt = dif[LIMB_W]; end
            OP_XOR:   res = a ^ b;
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_CMPEQ: wr = 1'b0;
            OP_CMPLT: begin cy_nxt = dif[LIMB_W]; wr = 1'b0; end
`ifdef SV_EX_SHIFT_EN
            OP_SHL1:  begin res = {a[LIMB_W-2:0], cy}; cy_nxt = a[LIMB_W-1]; end
            OP_SHR1:  begin res = {cy, a[LIMB_W-1:1]}; cy_nxt = a[0]; end
`endif
            OP_CLR:   res = '0;
            default:  wr = 1'b0;
        endcase
    end

    // Control FSM with registered handshake/status outputs
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state     <= S_IDLE;
            op        <= '0;
            rd        <= '0;
            rs1       <= '0;
            rs2       <= '0;
            idx       <= '0;
            cy        <= 1'b0;
            eq        <= 1'b1;
            ex.ex_r_o <= 1'b0;
            ex.ex_c_o <= 1'b0;
            ex.busy_o <= 1'b0;
            ex.err_o  <= 1'b0;
        end else begin
            ex.ex_r_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ex.ex_v_i) begin
                        op        <= ex.ex_i_i[3:0];
                        rd        <= ex.ex_i_i[6:4];
                        rs1       <= ex.ex_i_i[9:7];
                        rs2       <= ex.ex_i_i[12:10];
                        cy        <= 1'b0;
                        eq        <= 1'b1;
                        idx       <= '0;
`ifdef SV_EX_SHIFT_EN
                        if (ex.ex_i_i[3:0] == OP_SHR1)
                            idx <= LAST;
`endif
                        ex.busy_o <= 1'b1;
                        state     <= legal ? S_EXEC : S_ILL;
                    end
                end
                S_EXEC: begin
                    cy  <= cy_nxt;
                    eq  <= eq_nxt;
                    idx <= idx_nxt;
                    if (last) begin
                        state     <= S_DONE;
                        ex.ex_r_o <= 1'b1;
                        if (op == OP_CMPEQ) ex.ex_c_o <= eq_nxt;
                        if (op == OP_CMPLT) ex.ex_c_o <= cy_nxt;
                    end
                end
                S_ILL: begin
                    ex.err_o  <= 1'b1;
                    ex.ex_r_o <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    ex.busy_o <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Register file: host owns it in IDLE, the limb datapath during EXEC
    always_ff @(posedge clk) begin
        if (state == S_IDLE && ex.host_we)
            rf[ex.host_reg][ex.host_limb] <= ex.host_wdata;
        else if (state == S_EXEC && wr)
            rf[rd][idx] <= res;
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) ex.host_rdata <= '0;
        else         ex.host_rdata <= rf[ex.host_reg][ex.host_limb];
    end
endmodule

// File: tb/tb_sv_ex.sv
// tb_sv_ex: directed scoreboard bench for sv_ex; done events are checked by a separate monitor.
module tb_sv_ex;
    typedef struct {
        int unsigned at;
        bit          c;
        bit          err;
    } exp_t;

    logic        clk;
    logic        areset;
    int unsigned cyc;
    int unsigned checks;
    int unsigned errors;
    int unsigned done_cnt;
    int unsigned n_exp;
    exp_t        q[$];
    exp_t        mon_e;
    logic [511:0] v;
    bit          err_m;

    sv_ex_if #(.LIMB_W(32), .NL(16)) ex ();

    sv_ex u_dut (
        .clk    (clk),
        .areset (areset),
        .ex     (ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (areset === 1'b1 && ex.ex_r_o === 1'b1) begin
            done_cnt++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done act=done@%0d exp=none", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("done_cycle", 512'(cyc), 512'(mon_e.at));
                chk("done_ex_c", 512'(ex.ex_c_o), 512'(mon_e.c));
                chk("done_err", 512'(ex.err_o), 512'(mon_e.err));
            end
        end
    end

    task automatic host_wr(input int r, input int l, input logic [31:0] d);
        @(posedge clk); #1;
        ex.host_we = 1'b1; ex.host_reg = 3'(r); ex.host_limb = 4'(l); ex.host_wdata = d;
        @(posedge clk); #1;
        ex.host_we = 1'b0;
    endtask

    task automatic load_reg(input int r, input logic [511:0] val);
        for (int l = 0; l < 16; l++) host_wr(r, l, val[l*32 +: 32]);
    endtask

    task automatic rd_reg(input int r, output logic [511:0] val);
        for (int l = 0; l < 16; l++) begin
            @(posedge clk); #1;
            ex.host_reg = 3'(r); ex.host_limb = 4'(l);
            @(posedge clk); #1;
            val[l*32 +: 32] = ex.host_rdata;
        end
    endtask

    // Drive one execute word (optionally with a same-cycle host write); lat 0 means no done expected
    task automatic cmd(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                       input int lat, input bit c, input bit err,
                       input bit hw, input int hl, input logic [31:0] hd);
        @(posedge clk); #1;
        ex.ex_i_i = {2'b11, 3'(rs2), 3'(rs1), 3'(rd), op};
        ex.ex_v_i = 1'b1;
        ex.host_we = hw; ex.host_reg = 3'(rs1); ex.host_limb = 4'(hl); ex.host_wdata = hd;
        if (lat > 0) begin
            q.push_back('{cyc + 32'(lat), c, err});
            n_exp++;
        end
        @(posedge clk); #1;
        ex.ex_v_i = 1'b0;
        ex.host_we = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && done_cnt < n_exp; i++) @(negedge clk);
        if (done_cnt < n_exp) begin
            checks++;
            errors++;
            $display("FAIL done_timeout act=%0d exp=%0d", done_cnt, n_exp);
            done_cnt = n_exp;
            q.delete();
        end
    endtask

    task automatic run(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                       input int lat, input bit c, input bit err);
        cmd(op, rd, rs1, rs2, lat, c, err, 1'b0, 0, 32'h0);
        wait_done();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ex_r"}, 512'(ex.ex_r_o), 512'(0));
        chk({tag, "_ex_c"}, 512'(ex.ex_c_o), 512'(0));
        chk({tag, "_busy"}, 512'(ex.busy_o), 512'(0));
        chk({tag, "_err"}, 512'(ex.err_o), 512'(0));
        chk({tag, "_rdata"}, 512'(ex.host_rdata), 512'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; done_cnt = 0; n_exp = 0; err_m = 1'b0;
        areset = 1'b0;
        ex.ex_i_i = '0; ex.ex_v_i = 1'b0; ex.host_we = 1'b0;
        ex.host_reg = '0; ex.host_limb = '0; ex.host_wdata = '0;
        @(negedge clk);
        chk_reset_outputs("por");
        @(posedge clk); #1;
        areset = 1'b1;

        // ADD wrap: (2^512-1) + 1 = 0, done 17 cycles after issue, flag untouched
        load_reg(0, '1);
        load_reg(1, 512'd1);
        run(4'h1, 2, 0, 1, 17, 1'b0, 1'b0);
        rd_reg(2, v); chk("add_wrap_r2", v, 512'd0);

        // Compares and the held flag
        load_reg(0, 512'd5);
        load_reg(1, 512'd7);
        run(4'h7, 0, 0, 1, 17, 1'b1, 1'b0);
        run(4'h7, 0, 1, 0, 17, 1'b0, 1'b0);
        run(4'h6, 0, 0, 0, 17, 1'b1, 1'b0);
        run(4'h1, 4, 0, 1, 17, 1'b1, 1'b0);
        rd_reg(4, v); chk("add_r4", v, 512'd12);
        rd_reg(0, v); chk("cmp_no_write_r0", v, 512'd5);
        run(4'h2, 5, 0, 1, 17, 1'b1, 1'b0);
        rd_reg(5, v); chk("sub_wrap_r5", v, {{480{1'b1}}, 32'hFFFF_FFFE});
        run(4'h3, 6, 0, 1, 17, 1'b1, 1'b0);
        rd_reg(6, v); chk("xor_r6", v, 512'd2);
        run(4'h5, 6, 0, 1, 17, 1'b1, 1'b0);
        rd_reg(6, v); chk("or_r6", v, 512'd7);

        // Host write in the same cycle as MOV is visible to limb 0
        cmd(4'h0, 7, 1, 1, 17, 1'b1, 1'b0, 1'b1, 0, 32'd9);
        wait_done();
        rd_reg(7, v); chk("mov_same_cycle_r7", v, 512'd9);

        // Busy: extra execute word and host write at cycle 5 are both dropped
        cmd(4'h1, 2, 0, 1, 17, 1'b1, 1'b0, 1'b0, 0, 32'h0);
        repeat (3) begin @(posedge clk); #1; end
        ex.ex_i_i = {2'b00, 3'd0, 3'd0, 3'd3, 4'hF};
        ex.ex_v_i = 1'b1;
        ex.host_we = 1'b1; ex.host_reg = 3'd0; ex.host_limb = 4'd0; ex.host_wdata = 32'hDEAD;
        @(posedge clk); #1;
        ex.ex_v_i = 1'b0; ex.host_we = 1'b0;
        wait_done();
        repeat (25) @(negedge clk);
        chk("busy_single_done", 512'(done_cnt), 512'(n_exp));
        rd_reg(0, v); chk("busy_write_dropped", v, 512'd5);
        rd_reg(2, v); chk("busy_add_r2", v, 512'd14);

        // Illegal opcode: 2-cycle done, err set, rd untouched, flag held
        err_m = 1'b1;
        run(4'hF, 2, 0, 1, 2, 1'b1, err_m);
        chk("ill_err_sticky", 512'(ex.err_o), 512'(1));
        rd_reg(2, v); chk("ill_r2_unchanged", v, 512'd14);

        // Reset at cycle 8 of an ADD: no done, everything back to reset values
        cmd(4'h1, 2, 0, 1, 0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
        repeat (7) begin @(posedge clk); #1; end
        areset = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midop");
        @(posedge clk); #1;
        areset = 1'b1;
        repeat (25) @(negedge clk);
        chk("midop_no_done", 512'(done_cnt), 512'(n_exp));
        err_m = 1'b0;

        // New command after reset completes normally
        run(4'hA, 4, 0, 0, 17, 1'b0, 1'b0);
        rd_reg(4, v); chk("clr_r4", v, 512'd0);

        // In-place shifts across the limb 0/1 boundary
        load_reg(3, 512'd1 << 32);
`ifdef SV_EX_SHIFT_EN
        run(4'h9, 3, 3, 0, 17, 1'b0, 1'b0);
        rd_reg(3, v); chk("shr1_r3", v, 512'd1 << 31);
        run(4'h8, 3, 3, 0, 17, 1'b0, 1'b0);
        rd_reg(3, v); chk("shl1_r3", v, 512'd1 << 32);
`else
        err_m = 1'b1;
        run(4'h9, 3, 3, 0, 2, 1'b0, err_m);
        run(4'h8, 3, 3, 0, 2, 1'b0, err_m);
        rd_reg(3, v); chk("shift_off_r3", v, 512'd1 << 32);
`endif
        chk("final_err", 512'(ex.err_o), 512'(err_m));

        repeat (20) @(negedge clk);
        chk("pending_done", 512'(q.size()), 512'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sv_ex.md
# sv_ex

Limb-serial big-integer execution unit. It is the responder side of the sequencer's execute handshake. It accepts one 15-bit execute word per `ex_v_i` pulse and runs the operation over `BLOCK_SIZE`-bit registers, one `LIMB_W`-bit limb per cycle. On completion it returns a one-cycle done pulse and a held compare flag, which the sequencer uses for conditional jumps. A host port loads operands and reads results while the unit is idle.

## Interface
- `BLOCK_SIZE`, 512: operand width in bits; must be a multiple of `LIMB_W`.
- `LIMB_W`, 32: datapath width; `NL = BLOCK_SIZE/LIMB_W` limbs per register (16 at defaults).
- `NUM_REGS`, 8: register count; fixed by the 3-bit register fields.
- `clk` in 1: clock.
- `areset` in 1: asynchronous, active-low reset.
- `ex_i_i` in 15: execute word.
  - `[3:0]` opcode, `[6:4]` rd, `[9:7]` rs1, `[12:10]` rs2.
  - `[14:13]` reserved; ignored.
- `ex_v_i` in 1: execute-valid pulse; `ex_i_i` is sampled in the same cycle.
- `ex_r_o` out 1: done pulse, exactly one cycle per accepted command.
- `ex_c_o` out 1: compare flag; holds its value until the next compare instruction.
- `busy_o` out 1: high while not IDLE.
- `err_o` out 1: sticky illegal-opcode flag.
- `host_we` in 1: host limb write.
- `host_reg` in 3: host register select.
- `host_limb` in `$clog2(NL)`: host limb select; limb 0 is least significant.
- `host_wdata` in `LIMB_W`: host write data.
- `host_rdata` out `LIMB_W`: registered read data for `host_reg`/`host_limb`.

## Operation
- **Opcodes.** All arithmetic is unsigned and modulo 2^BLOCK_SIZE.
  - 0x0 MOV: rd = rs1.
  - 0x1 ADD: rd = rs1 + rs2.
  - 0x2 SUB: rd = rs1 - rs2.
  - 0x3 XOR, 0x4 AND, 0x5 OR: bitwise on rs1, rs2.
  - 0x6 CMPEQ: ex_c = (rs1 == rs2).
  - 0x7 CMPLT: ex_c = (rs1 < rs2).
  - 0x8 SHL1: rd = rs1 << 1.
  - 0x9 SHR1: rd = rs1 >> 1.
  - 0xA CLR: rd = 0.
  - 0xB–0xF: illegal.
- **Compare flag.** Only CMPEQ and CMPLT write `ex_c_o`. CMPLT is the final borrow of rs1 - rs2. CMPEQ is the AND over all limbs of limb equality. Compares never write rd.
- **States.**
  - IDLE: on `ex_v_i`, latch opcode and fields, clear the limb counter and carry/borrow. Go to EXEC if legal, else to ILL.
  - EXEC: process one limb per cycle; after limb index NL-1, go to DONE.
  - ILL: set `err_o`, go to DONE; no register or flag change.
  - DONE: `ex_r_o`=1 for this cycle; write `ex_c_o` (compares only); return to IDLE.
- **Limb order.**
  - LSB-first (limb 0 → NL-1) for all opcodes except SHR1.
  - SHR1 runs MSB-first. A bit register carries the previous (higher) limb's bit 0 into bit `LIMB_W-1` and starts at 0.
  - SHL1 carries bit `LIMB_W-1` upward and starts at 0.
- **In-place safety.** Each EXEC cycle reads rs1[i] and rs2[i] and writes rd[i]. Therefore rd == rs1 and/or rd == rs2 give correct results.
- **`ex_v_i` while busy.** Ignored: no queueing, no error, no extra `ex_r_o`.
- **Host port.**
  - `host_we` in IDLE writes immediately.
  - `host_we` while busy is dropped.
  - If `host_we` and `ex_v_i` arrive in the same IDLE cycle, both are performed; the write is visible to limb 0 of the command.
  - Reads are allowed anytime; `host_rdata` has 1-cycle latency and shows post-write data from the following cycle.

## Timing
- **Reset values.** `ex_r_o`=0, `ex_c_o`=0, `busy_o`=0, `err_o`=0, `host_rdata`=0, state IDLE. Register file contents are undefined (not reset).
- **Legal command.** `ex_v_i` at cycle 0 → EXEC cycles 1..NL → `ex_r_o` at cycle NL+1 (17 at defaults) → IDLE at NL+2. Next acceptable `ex_v_i` is cycle NL+2.
- **Illegal command.** `ex_v_i` at cycle 0 → `ex_r_o` at cycle 2; `err_o` high from cycle 2.
- **Outputs at done.** `ex_c_o` and rd are final in the same cycle `ex_r_o` is high.
- **Reset mid-command.** Returns to IDLE with no `ex_r_o`. rd may be partially written.

## Configuration
- `SV_EX_SHIFT_EN` defined: SHL1/SHR1 are implemented, including the MSB-first counter direction.
- Undefined: opcodes 0x8 and 0x9 are illegal (ILL path, `err_o` set, 2-cycle done), and the down-counting limb path is not built.

## Test plan
- **ADD wrap.** Host loads r0 = 2^512-1, r1 = 1; ADD r2,r0,r1 → r2 = 0; `ex_r_o` exactly at cycle 17; `ex_c_o` unchanged (0).
- **CMPLT / CMPEQ.** r0 = 5, r1 = 7. CMPLT r0,r1 → `ex_c_o` = 1 at done. CMPLT r1,r0 → 0. CMPEQ r0,r0 → 1, held through a following ADD.
- **In-place shift, cross-limb carry.** r3 = 2^32 (limb 1 bit 0). SHR1 r3,r3 → r3 = 2^31. SHL1 r3,r3 → 2^32. Without `SV_EX_SHIFT_EN`: `err_o` = 1, r3 unchanged.
- **Illegal opcode.** Opcode 0xF → `ex_r_o` at cycle 2, `err_o` stays 1, no register written.
- **Busy behaviour.** Second `ex_v_i` at cycle 5 of an ADD → ignored, single `ex_r_o`. `host_we` at cycle 5 → write dropped (read back the old value).
- **Reset mid-op.** `areset` low at cycle 8 of an ADD → all outputs at reset values, no `ex_r_o`. A new command afterwards completes normally.
